bk_wide_add_seq: RTL
====================

// Module: bk_wide_add_seq
// PURPOSE
//  Sequencer that time-multiplexes one 4-bit Brent-Kung adder slice (bkadder_4) to add two
//  NWORDS*4-bit operands, least significant slice first, rippling carry between slices over cycles.
//  Sits between a valid/ready operand source and result sink; the slice is instantiated outside
//  and connected through the ADD_* ports, so registered and combinational slice builds both work.
// PARAMETERS
//  NWORDS   4  number of 4-bit slices per operand (operand width W = 4*NWORDS), >=1
//  ADD_LAT  1  cycles from ADD_A/ADD_B/ADD_CIN change to valid ADD_S/ADD_COUT, >=0
// PORTS
//  CLK        in   1   single clock, all state updates on rising edge
//  RST        in   1   reset, synchronous, active-high
//  IN_VALID   in   1   operand request valid
//  IN_READY   out  1   block accepts operands (IN handshake = IN_VALID & IN_READY)
//  IN_A       in   W   operand A
//  IN_B       in   W   operand B
//  IN_CIN     in   1   carry-in to slice 0
//  OUT_VALID  out  1   result valid
//  OUT_READY  in   1   sink accepts result (OUT handshake = OUT_VALID & OUT_READY)
//  OUT_SUM    out  W   sum, registered
//  OUT_COUT   out  1   carry-out of top slice, registered
//  ADD_A      out  4   slice operand A
//  ADD_B      out  4   slice operand B
//  ADD_CIN    out  1   slice carry-in
//  ADD_S      in   4   slice sum
//  ADD_COUT   in   1   slice carry-out
// BEHAVIOUR
//  FSM: IDLE -> RUN on IN handshake; RUN -> DONE after last slice sampled; DONE -> IDLE on OUT handshake.
//  Reset (RST high at an edge): state=IDLE, slice index k=0, wait counter=0, OUT_SUM=0, OUT_COUT=0,
//   OUT_VALID=0, ADD_A/ADD_B/ADD_CIN=0. IN_READY=0 during any cycle RST is high.
//  IN_READY = (state==IDLE) & ~RST. IN_A/IN_B/IN_CIN are captured into internal registers at the
//   handshake edge; later changes on IN_* have no effect.
//  RUN, slice k (k=0..NWORDS-1): ADD_A=A[4k+3:4k], ADD_B=B[4k+3:4k], ADD_CIN=carry register
//   (IN_CIN for k=0), held stable for ADD_LAT+1 cycles; ADD_S/ADD_COUT sampled at the edge that
//   ends the last of those cycles, into OUT_SUM[4k+3:4k] and the carry register; then k increments.
//  In IDLE/DONE, ADD_A/ADD_B/ADD_CIN are driven 0.
//  Latency: OUT_VALID rises exactly NWORDS*(ADD_LAT+1) cycles after the IN handshake edge.
//  OUT_COUT = ADD_COUT sampled for slice NWORDS-1. OUT_SUM bits of unprocessed slices read 0
//   during RUN; OUT_SUM/OUT_COUT are valid only while OUT_VALID=1.
//  DONE: OUT_VALID=1; OUT_SUM/OUT_COUT held stable until OUT handshake; IN_READY=0 (no accept in the
//   same cycle as OUT handshake; IDLE is always visited for at least one cycle).
//  Sum is modulo 2^W; carry beyond the top slice appears only on OUT_COUT.
//  Reset mid-RUN/DONE: operation abandoned, no OUT_VALID for it; the next cycle is the reset state.
// CONFIGURATION
//  BK_SEQ_OVF_EN defined: extra port OUT_OVF out 1 = signed two's-complement overflow,
//   (A[W-1]==B[W-1]) & (OUT_SUM[W-1]!=A[W-1]), registered with the top slice; 0 on reset; held in DONE.
//  BK_SEQ_OVF_EN undefined: no OUT_OVF port and no overflow logic.
// TESTING (NWORDS=4, ADD_LAT=1, bkadder_4 registered slice unless noted)
//  A=16'hFFFF,B=16'h0001,CIN=0 -> OUT_SUM=16'h0000, OUT_COUT=1, OUT_VALID exactly 8 cycles after accept.
//  A=16'h1234,B=16'h4321,CIN=1 -> OUT_SUM=16'h5556, OUT_COUT=0; IN_READY=0 from accept until after OUT handshake.
//  Hold OUT_READY=0 for 5 cycles in DONE -> OUT_VALID, OUT_SUM, OUT_COUT stable; IN_READY=0 throughout.
//  RST=1 for one cycle in 3rd RUN cycle -> next cycle OUT_VALID=0, IN_READY=1, ADD_*=0; next add
//   A=16'h00FF,B=16'h0001 -> 16'h0100, COUT=0.
//  ADD_LAT=0 with combinational slice: A=16'h8000,B=16'h8000,CIN=0 -> SUM=0, COUT=1, latency 4 cycles.
//  BK_SEQ_OVF_EN: 16'h7FFF+16'h0001 -> OUT_OVF=1; 16'h8000+16'h8000 -> OUT_OVF=1; 16'h0001+16'hFFFF -> OUT_OVF=0.

Source files
------------

// File: rtl/bk_wide_add_seq_if.sv
// Operand request / result handshake bundle for bk_wide_add_seq.
// out_ovf exists only when BK_SEQ_OVF_EN is defined.
interface bk_wide_add_seq_if #(
  parameter int NWORDS = 4
);
  localparam int W = 4 * NWORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef BK_SEQ_OVF_EN
  logic         out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
`ifdef BK_SEQ_OVF_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
`ifdef BK_SEQ_OVF_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/bk_wide_add_seq.sv
// Time-multiplexes an external 4-bit adder slice over NWORDS slices, LSB slice first.
// Optional signed-overflow output enabled by defining BK_SEQ_OVF_EN.
module bk_wide_add_seq #(
  parameter int NWORDS  = 4,
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  bk_wide_add_seq_if.slave  bus,
  output logic [3:0]        add_a,
  output logic [3:0]        add_b,
  output logic              add_cin,
  input  logic [3:0]        add_s,
  input  logic              add_cout
);
  localparam int W  = 4 * NWORDS;
  localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int CW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(ADD_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [KW-1:0] k_r;
  logic [KW-1:0] k_inc_s;
  logic [CW-1:0] wait_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  sum_r;
  logic          cout_r;
  logic          valid_r;
  logic [3:0]    add_a_r;
  logic [3:0]    add_b_r;
  logic          add_cin_r;
  logic          accept_s;
  logic          sample_s;
  logic          last_s;
`ifdef BK_SEQ_OVF_EN
  logic          ovf_r;
`endif

  assign k_inc_s = k_r + 1'b1;

  // Next-state decode plus accept / slice-sample strobes
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    sample_s   = 1'b0;
    last_s     = (k_r == K_LAST);
    case (state_r)
      S_IDLE: begin
        if (bus.in_valid) begin
          accept_s   = 1'b1;
          state_nx_s = S_RUN;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (wait_r == C_LAST) begin
          sample_s = 1'b1;
          if (last_s) begin
            state_nx_s = S_DONE;
          end else begin
            state_nx_s = S_RUN;
          end
        end else begin
          state_nx_s = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_DONE;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand capture, slice sequencing and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r       <= {KW{1'b0}};
      wait_r    <= {CW{1'b0}};
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      sum_r     <= {W{1'b0}};
      cout_r    <= 1'b0;
      valid_r   <= 1'b0;
      add_a_r   <= 4'h0;
      add_b_r   <= 4'h0;
      add_cin_r <= 1'b0;
`ifdef BK_SEQ_OVF_EN
      ovf_r     <= 1'b0;
`endif
    end else begin
      if (accept_s) begin
        // Slice 0 is presented from the handshake edge so the first wait window starts at once
        a_r       <= bus.in_a;
        b_r       <= bus.in_b;
        sum_r     <= {W{1'b0}};
        cout_r    <= 1'b0;
        k_r       <= {KW{1'b0}};
        wait_r    <= {CW{1'b0}};
        add_a_r   <= bus.in_a[3:0];
        add_b_r   <= bus.in_b[3:0];
        add_cin_r <= bus.in_cin;
`ifdef BK_SEQ_OVF_EN
        ovf_r     <= 1'b0;
`endif
      end else if (state_r == S_RUN) begin
        if (sample_s) begin
          sum_r[{k_r, 2'b00} +: 4] <= add_s;
          wait_r                   <= {CW{1'b0}};
          if (last_s) begin
            cout_r    <= add_cout;
            add_a_r   <= 4'h0;
            add_b_r   <= 4'h0;
            add_cin_r <= 1'b0;
`ifdef BK_SEQ_OVF_EN
            ovf_r     <= (a_r[W-1] == b_r[W-1]) & (add_s[3] != a_r[W-1]);
`endif
          end else begin
            k_r       <= k_inc_s;
            add_a_r   <= 4'(a_r >> {k_inc_s, 2'b00});
            add_b_r   <= 4'(b_r >> {k_inc_s, 2'b00});
            add_cin_r <= add_cout;
          end
        end else begin
          wait_r <= wait_r + 1'b1;
        end
      end else begin
        wait_r <= {CW{1'b0}};
      end
      valid_r <= (state_nx_s == S_DONE);
    end
  end

  assign bus.in_ready  = (state_r == S_IDLE) & ~rst;
  assign bus.out_valid = valid_r;
  assign bus.out_sum   = sum_r;
  assign bus.out_cout  = cout_r;
`ifdef BK_SEQ_OVF_EN
  assign bus.out_ovf   = ovf_r;
`endif
  assign add_a   = add_a_r;
  assign add_b   = add_b_r;
  assign add_cin = add_cin_r;
endmodule
